// File: rtl/trap_ctrl_mc_pkg.sv
// trap_ctrl_mc_pkg: cause codes, mstatus bit positions, mtvec modes and FSM state for the trap controller
package trap_ctrl_mc_pkg;
  localparam int PC_MISALIGNED = 0;
  localparam int ILLEGAL_INSTR = 2;
  localparam int LOAD_ACCESS_FAULT = 5;
  localparam int M_ECALL = 11;
  localparam int MSTATUS_MIE_BIT = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam logic [1:0] MTVEC_DIRECT = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
  typedef enum logic {RUN, REQ} state_t;
endpackage

// File: rtl/trap_ctrl_mc_irq_sync.sv
// irq_sync: STAGES-deep synchroniser for one asynchronous level line; STAGES=0 passes through
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic cpu_clk,
  input  logic cpu_rstn,
  input  logic d,
  output logic q
);
  if (STAGES == 0) begin : g_pass
    assign q = d;
  end else begin : g_ff
    logic [STAGES-1:0] s;
    always_ff @(posedge cpu_clk) s <= !cpu_rstn ? '0 : STAGES'({s, d});
    assign q = s[STAGES-1];
  end
endmodule

// File: rtl/trap_ctrl_mc.sv
// trap_ctrl_mc: prioritised multi-line trap controller with mstatus MIE/MPIE stack and fetch handshake.
// Define TRAP_NMI_EN to add an edge-triggered non-maskable interrupt (nmi_in, nmi_vector).
module trap_ctrl_mc
  import trap_ctrl_mc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_CODE_BASE = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] fault_pc,
  input  logic                  pc_misaligned,
  input  logic                  instr_illegal,
  input  logic                  csr_illegal_access,
  input  logic                  ecall,
  input  logic                  load_fault,
  input  logic [DATA_WIDTH-1:0] illegal_instr,
  input  logic                  mret,
  input  logic                  csr_wr,
  input  logic                  csr_set,
  input  logic                  csr_clr,
  input  logic                  mepc_sel,
  input  logic                  mcause_sel,
  input  logic                  mtval_sel,
  input  logic                  mie_sel,
  input  logic                  mstatus_sel,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [1:0]            mtvec_mode,
  input  logic [ADDR_WIDTH-1:0] mtvec_base,
  input  logic                  trap_ack,
`ifdef TRAP_NMI_EN
  input  logic                  nmi_in,
  input  logic [ADDR_WIDTH-1:0] nmi_vector,
`endif
  output logic                  trap,
  output logic [ADDR_WIDTH-1:0] vector_addr,
  output logic [ADDR_WIDTH-1:0] mepc,
  output logic [DATA_WIDTH-1:0] mcause,
  output logic [DATA_WIDTH-1:0] mtval,
  output logic [NUM_IRQ-1:0]    mip,
  output logic [NUM_IRQ-1:0]    mie,
  output logic                  mstatus_mie,
  output logic                  mstatus_mpie
);
  localparam logic [DATA_WIDTH-1:0] INT_MSB = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  state_t state, state_d;
  logic [NUM_IRQ-1:0] irq_s, pend;
  logic [3:0] win;
  logic [DATA_WIDTH-1:0] irq_code, cause_d, tval_d;
  logic [ADDR_WIDTH-1:0] vec_q, vec_d;
  logic run, ill, exc, irq_ok, nmi_take, take, csr_we;
  function automatic logic [DATA_WIDTH-1:0] csr_f(input logic [DATA_WIDTH-1:0] o);
    return csr_set ? o | csr_wdata : csr_clr ? o & ~csr_wdata : csr_wdata;
  endfunction
  function automatic logic csr_b(input logic o, input logic w);
    return csr_set ? o | w : csr_clr ? o & ~w : w;
  endfunction
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (.cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .d(irq_in[i]), .q(irq_s[i]));
  end
`ifdef TRAP_NMI_EN
  logic nmi_s, nmi_q, nmi_pend, nmi_edge;
  irq_sync #(.STAGES(SYNC_STAGES)) u_nmi (.cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .d(nmi_in), .q(nmi_s));
  assign nmi_edge = nmi_s & ~nmi_q;
  assign nmi_take = run & ~exc & (nmi_pend | nmi_edge);
  // edges seen during REQ or behind an exception wait here until they can be taken
  always_ff @(posedge cpu_clk) begin
    nmi_q <= cpu_rstn & nmi_s;
    nmi_pend <= cpu_rstn & (nmi_pend | nmi_edge) & ~nmi_take;
  end
`else
  assign nmi_take = 1'b0;
`endif
  assign pend = mip & mie;
  always_comb begin
    win = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) win = pend[k] ? 4'(k) : win;
  end
  assign run = state == RUN;
  assign ill = instr_illegal | csr_illegal_access;
  assign exc = pc_misaligned | ill | ecall | load_fault;
  assign irq_ok = mstatus_mie & |pend;
  assign take = run & (exc | nmi_take | irq_ok);
  assign csr_we = csr_wr | csr_set | csr_clr;
  assign irq_code = DATA_WIDTH'(IRQ_CODE_BASE) + DATA_WIDTH'(win);
  assign cause_d = exc ? DATA_WIDTH'(pc_misaligned ? PC_MISALIGNED : ill ? ILLEGAL_INSTR : ecall ? M_ECALL : LOAD_ACCESS_FAULT)
                 : nmi_take ? INT_MSB : INT_MSB | irq_code;
  assign tval_d = pc_misaligned ? DATA_WIDTH'(fault_pc) : ill ? illegal_instr : '0;
  always_comb begin
    vec_d = (!exc && mtvec_mode == MTVEC_VECTORED) ? mtvec_base + (ADDR_WIDTH'(irq_code) << 2) : mtvec_base;
`ifdef TRAP_NMI_EN
    vec_d = nmi_take ? nmi_vector : vec_d;
`endif
  end
  assign vector_addr = vec_q;
  always_comb begin
    state_d = run ? (take ? REQ : RUN) : (trap_ack ? RUN : REQ);
    trap = state == REQ;
  end
  always_ff @(posedge cpu_clk) state <= !cpu_rstn ? RUN : state_d;
  // a trap take swallows any same-cycle CSR write and mret
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      mepc <= '0;
      mcause <= '1;
      mtval <= '0;
      mip <= '0;
      mie <= '0;
      mstatus_mie <= 1'b0;
      mstatus_mpie <= 1'b1;
      vec_q <= '0;
    end else begin
      mip <= irq_s;
      if (take) begin
        mepc <= pc;
        mcause <= cause_d;
        mtval <= tval_d;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie <= 1'b0;
        vec_q <= vec_d;
      end else begin
        if (csr_we && mepc_sel) mepc <= ADDR_WIDTH'(csr_f(DATA_WIDTH'(mepc)));
        if (csr_we && mcause_sel) mcause <= csr_f(mcause);
        if (csr_we && mtval_sel) mtval <= csr_f(mtval);
        if (csr_we && mie_sel) mie <= NUM_IRQ'(csr_f(DATA_WIDTH'(mie)));
        if (run && mret) begin
          mstatus_mie <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end else if (csr_we && mstatus_sel) begin
          mstatus_mie <= csr_b(mstatus_mie, csr_wdata[MSTATUS_MIE_BIT]);
          mstatus_mpie <= csr_b(mstatus_mpie, csr_wdata[MSTATUS_MPIE_BIT]);
        end
      end
    end
  end
endmodule

// File: tb/tb_trap_ctrl_mc.sv
// tb_trap_ctrl_mc: scoreboard bench for trap_ctrl_mc; exercises NMI too when TRAP_NMI_EN is defined
module tb_trap_ctrl_mc;
  logic cpu_clk = 0, cpu_rstn = 0;
  logic [3:0] irq_in = '0;
  logic [31:0] pc = '0, fault_pc = '0, illegal_instr = '0, csr_wdata = '0, mtvec_base = 32'h100;
  logic pc_misaligned = 0, instr_illegal = 0, csr_illegal_access = 0, ecall = 0, load_fault = 0, mret = 0;
  logic csr_wr = 0, csr_set = 0, csr_clr = 0, trap_ack = 0;
  logic mepc_sel = 0, mcause_sel = 0, mtval_sel = 0, mie_sel = 0, mstatus_sel = 0;
  logic [1:0] mtvec_mode = 2'b01;
  logic trap, mstatus_mie, mstatus_mpie;
  logic [31:0] vector_addr, mepc, mcause, mtval;
  logic [3:0] mip, mie;
`ifdef TRAP_NMI_EN
  logic nmi_in = 0;
  logic [31:0] nmi_vector = 32'h900;
`endif
  typedef struct packed {logic [31:0] cause, epc, tval, vec;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;
  bit ok;

  trap_ctrl_mc dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .irq_in(irq_in), .pc(pc), .fault_pc(fault_pc),
    .pc_misaligned(pc_misaligned), .instr_illegal(instr_illegal), .csr_illegal_access(csr_illegal_access),
    .ecall(ecall), .load_fault(load_fault), .illegal_instr(illegal_instr), .mret(mret),
    .csr_wr(csr_wr), .csr_set(csr_set), .csr_clr(csr_clr), .mepc_sel(mepc_sel), .mcause_sel(mcause_sel),
    .mtval_sel(mtval_sel), .mie_sel(mie_sel), .mstatus_sel(mstatus_sel), .csr_wdata(csr_wdata),
    .mtvec_mode(mtvec_mode), .mtvec_base(mtvec_base), .trap_ack(trap_ack),
`ifdef TRAP_NMI_EN
    .nmi_in(nmi_in), .nmi_vector(nmi_vector),
`endif
    .trap(trap), .vector_addr(vector_addr), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .mip(mip), .mie(mie), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic csr_op(input int sel, input int kind, input logic [31:0] d);
    {mepc_sel, mcause_sel, mtval_sel, mie_sel, mstatus_sel} = 5'b10000 >> sel;
    {csr_wr, csr_set, csr_clr} = 3'b100 >> kind;
    csr_wdata = d;
    tick;
    {mepc_sel, mcause_sel, mtval_sel, mie_sel, mstatus_sel, csr_wr, csr_set, csr_clr} = '0;
  endtask

  task automatic wait_trap(output bit seen);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (trap === 1'b1) seen = 1;
      else tick;
    end
  endtask

  task automatic do_ack;
    trap_ack = 1;
    tick;
    trap_ack = 0;
  endtask

  task automatic test_reset;
    cpu_rstn = 0;
    repeat (3) tick;
    n_cmp++;
    if ({trap, mepc, mcause, mtval, mip, mie, mstatus_mie, mstatus_mpie} !==
        {1'b0, 32'h0, 32'hffff_ffff, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset: trap=%b mepc=%h mcause=%h mtval=%h mip=%h mie=%h ms=%b%b", trap, mepc, mcause, mtval, mip, mie, mstatus_mie, mstatus_mpie);
    end
    cpu_rstn = 1;
    tick;
  endtask

  task automatic test_irq_vectored;
    csr_op(3, 0, 32'h5);
    csr_op(4, 0, 32'h88);
    pc = 32'h400;
    sb.push_back({32'h8000_0000 | (16 + 2), 32'h400, 32'h0, 32'h100 + ((16 + 2) << 2)});
    irq_in = 4'b0100;
    tick;
    tick;
    n_cmp++;
    if (mip[2] !== 1'b0) begin n_err++; $display("FAIL mip_early: got %b want 0", mip[2]); end
    tick;
    n_cmp++;
    if ({mip[2], trap} !== 2'b10) begin n_err++; $display("FAIL mip_latency: got mip2/trap=%b%b want 10", mip[2], trap); end
    wait_trap(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL irq_vec_timeout: got no trap want trap"); end
    e = sb.pop_front();
    n_cmp++;
    if ({mcause, mepc, mtval, vector_addr} !== e) begin n_err++; $display("FAIL irq_vec: got %h want %h", {mcause, mepc, mtval, vector_addr}, e); end
    n_cmp++;
    if ({mstatus_mie, mstatus_mpie} !== 2'b01) begin n_err++; $display("FAIL irq_mstatus: got %b%b want 01", mstatus_mie, mstatus_mpie); end
    irq_in = '0;
    repeat (4) tick;
    n_cmp++;
    if (trap !== 1'b1) begin n_err++; $display("FAIL irq_drop_hold: got trap=%b want 1", trap); end
    do_ack;
    n_cmp++;
    if (trap !== 1'b0) begin n_err++; $display("FAIL irq_ack: got trap=%b want 0", trap); end
  endtask

  task automatic test_priority_hold;
    mret = 1;
    tick;
    mret = 0;
    n_cmp++;
    if ({mstatus_mie, mstatus_mpie} !== 2'b11) begin n_err++; $display("FAIL mret: got %b%b want 11", mstatus_mie, mstatus_mpie); end
    csr_op(3, 0, 32'hF);
    pc = 32'h600;
    sb.push_back({32'h8000_0000 | (16 + 1), 32'h600, 32'h0, 32'h100 + ((16 + 1) << 2)});
    irq_in = 4'b1010;
    wait_trap(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL prio_timeout: got no trap want trap"); end
    e = sb.pop_front();
    n_cmp++;
    if ({mcause, mepc, mtval, vector_addr} !== e) begin n_err++; $display("FAIL prio: got %h want %h", {mcause, mepc, mtval, vector_addr}, e); end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++;
      if (trap !== 1'b1) begin n_err++; $display("FAIL prio_hold%0d: got trap=%b want 1", i, trap); end
    end
    do_ack;
    n_cmp++;
    if (trap !== 1'b0) begin n_err++; $display("FAIL prio_ack: got trap=%b want 0", trap); end
    irq_in = '0;
    repeat (4) tick;
  endtask

  task automatic test_ecall_over_irq;
    irq_in = 4'b0001;
    repeat (4) tick;
    n_cmp++;
    if ({mip[0], trap} !== 2'b10) begin n_err++; $display("FAIL masked_pend: got mip0/trap=%b%b want 10", mip[0], trap); end
    mret = 1;
    tick;
    mret = 0;
    pc = 32'h2000;
    ecall = 1;
    sb.push_back({32'd11, 32'h2000, 32'h0, 32'h100});
    tick;
    ecall = 0;
    wait_trap(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL ecall_timeout: got no trap want trap"); end
    e = sb.pop_front();
    n_cmp++;
    if ({mcause, mepc, mtval, vector_addr} !== e) begin n_err++; $display("FAIL ecall_irq: got %h want %h", {mcause, mepc, mtval, vector_addr}, e); end
    do_ack;
    irq_in = '0;
    repeat (4) tick;
  endtask

  task automatic test_exceptions;
    logic [4:0] fl [5] = '{5'b11000, 5'b01000, 5'b00100, 5'b00011, 5'b00001};
    logic [31:0] ec [5] = '{32'd0, 32'd2, 32'd2, 32'd11, 32'd5};
    logic [31:0] tv [5] = '{32'h1002, 32'hdead_beef, 32'hdead_beef, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      pc = 32'h3000 + 32'(i * 4);
      fault_pc = 32'h1002;
      illegal_instr = 32'hdead_beef;
      {pc_misaligned, instr_illegal, csr_illegal_access, ecall, load_fault} = fl[i];
      sb.push_back({ec[i], pc, tv[i], 32'h100});
      tick;
      {pc_misaligned, instr_illegal, csr_illegal_access, ecall, load_fault} = '0;
      wait_trap(ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {mcause, mepc, mtval, vector_addr} !== e) begin
        n_err++;
        $display("FAIL exc%0d: got trap=%b %h want %h", i, trap, {mcause, mepc, mtval, vector_addr}, e);
      end
      do_ack;
    end
  endtask

  task automatic test_conflicts;
    pc = 32'h4000;
    {ecall, mret, csr_wr, mepc_sel} = 4'b1111;
    csr_wdata = 32'h55;
    sb.push_back({32'd11, 32'h4000, 32'h0, 32'h100});
    tick;
    {ecall, mret, csr_wr, mepc_sel} = '0;
    wait_trap(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {mcause, mepc, mtval, vector_addr} !== e) begin
      n_err++;
      $display("FAIL take_vs_csr: got trap=%b %h want %h", trap, {mcause, mepc, mtval, vector_addr}, e);
    end
    n_cmp++;
    if ({mstatus_mie, mstatus_mpie} !== 2'b00) begin n_err++; $display("FAIL take_vs_mret: got %b%b want 00", mstatus_mie, mstatus_mpie); end
    csr_op(2, 0, 32'h77);
    n_cmp++;
    if ({trap, mtval} !== {1'b1, 32'h77}) begin n_err++; $display("FAIL csr_in_req: got trap=%b mtval=%h want 1 77", trap, mtval); end
    do_ack;
    {mret, mstatus_sel, csr_wr} = 3'b111;
    csr_wdata = 32'h08;
    tick;
    {mret, mstatus_sel, csr_wr} = '0;
    n_cmp++;
    if ({mstatus_mie, mstatus_mpie} !== 2'b01) begin n_err++; $display("FAIL mret_vs_csr: got %b%b want 01", mstatus_mie, mstatus_mpie); end
    csr_op(3, 2, 32'h5);
    n_cmp++;
    if (mie !== 4'hA) begin n_err++; $display("FAIL mie_clr: got %h want a", mie); end
    csr_op(3, 1, 32'h1);
    n_cmp++;
    if (mie !== 4'hB) begin n_err++; $display("FAIL mie_set: got %h want b", mie); end
    csr_op(1, 0, 32'h1234);
    n_cmp++;
    if (mcause !== 32'h1234) begin n_err++; $display("FAIL mcause_wr: got %h want 1234", mcause); end
  endtask

  task automatic test_reset_in_req;
    pc = 32'h7000;
    load_fault = 1;
    sb.push_back({32'd5, 32'h7000, 32'h0, 32'h100});
    tick;
    load_fault = 0;
    wait_trap(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {mcause, mepc, mtval, vector_addr} !== e) begin
      n_err++;
      $display("FAIL load_fault: got trap=%b %h want %h", trap, {mcause, mepc, mtval, vector_addr}, e);
    end
    cpu_rstn = 0;
    tick;
    n_cmp++;
    if ({trap, mcause, mepc} !== {1'b0, 32'hffff_ffff, 32'h0}) begin
      n_err++;
      $display("FAIL reset_in_req: got trap=%b mcause=%h mepc=%h want 0 ffffffff 0", trap, mcause, mepc);
    end
    cpu_rstn = 1;
    tick;
  endtask

`ifdef TRAP_NMI_EN
  task automatic test_nmi;
    pc = 32'h5000;
    sb.push_back({32'h8000_0000, 32'h5000, 32'h0, 32'h900});
    nmi_in = 1;
    tick;
    tick;
    nmi_in = 0;
    wait_trap(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {mcause, mepc, mtval, vector_addr} !== e) begin
      n_err++;
      $display("FAIL nmi: got trap=%b %h want %h", trap, {mcause, mepc, mtval, vector_addr}, e);
    end
    sb.push_back({32'h8000_0000, 32'h5000, 32'h0, 32'h900});
    nmi_in = 1;
    tick;
    tick;
    nmi_in = 0;
    repeat (4) tick;
    do_ack;
    n_cmp++;
    if (trap !== 1'b0) begin n_err++; $display("FAIL nmi_ack: got trap=%b want 0", trap); end
    wait_trap(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {mcause, mepc, mtval, vector_addr} !== e) begin
      n_err++;
      $display("FAIL nmi_pending: got trap=%b %h want %h", trap, {mcause, mepc, mtval, vector_addr}, e);
    end
    do_ack;
  endtask
`endif

  initial begin
    test_reset;
    test_irq_vectored;
    test_priority_hold;
    test_ecall_over_irq;
    test_exceptions;
    test_conflicts;
    test_reset_in_req;
`ifdef TRAP_NMI_EN
    test_nmi;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
